// File: rtl/popcount_pipe.sv
// -----------------------------------------------------------------------------
// popcount_pipe
//
// Streaming population-count engine. It counts the set bits of each WIDTH-bit
// input beat and accumulates the counts across the beats of a packet. It emits
// one total per packet, on the beat that carries in_last. There are two
// pipeline stages:
//   stage 1 : per-half popcount of the incoming beat
//   stage 2 : packet accumulator and output register
// A single stall enable (en = !out_valid || out_ready) freezes both stages
// while a total is waiting for the consumer.
//
// Optional feature (macro POPCOUNT_PIPE_SAT_EN):
//   defined   -> the accumulator clamps at 2^ACC_WIDTH-1. A sticky flag
//                records any clamp within a packet and is reported on out_sat.
//   undefined -> the accumulator wraps modulo 2^ACC_WIDTH, and out_sat is 0.
//
// Parameters:
//   WIDTH     : input beat width (power of two, >= 4)
//   ACC_WIDTH : accumulator / total width (>= $clog2(WIDTH)+1)
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_valid   : beat offered
//   in_ready   : beat can be accepted this cycle
//   in_data    : bit vector to count
//   in_last    : final beat of its packet
//   out_valid  : packet total available
//   out_ready  : consumer accepts the total
//   out_count  : packet popcount total
//   out_sat    : total was clamped (saturation builds only)
// -----------------------------------------------------------------------------
module popcount_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH);

    // A half-width count reaches at most WIDTH/2, which fits in $clog2(WIDTH) bits.
    function automatic logic [CW-1:0] popcount_half(input logic [HALF-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < HALF; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

`ifdef POPCOUNT_PIPE_SAT_EN
    // Returns {clamped, sum}. The sum is pinned at all-ones when the add carries out.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_WIDTH]) begin
            s = {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return s;
    endfunction
`endif

    logic                 w_en;
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic [CW-1:0]        r_s1_lo;
    logic [CW-1:0]        r_s1_hi;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_count;
    logic [ACC_WIDTH-1:0] w_beat_sum;
    logic [ACC_WIDTH-1:0] w_tot;

    // The stall depends only on the output side, so in_ready never waits on in_valid.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // ---- stage 1: split popcount --------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_lo <= popcount_half(in_data[HALF-1:0]);
            r_s1_hi <= popcount_half(in_data[WIDTH-1:HALF]);
        end
    end

    // ---- stage 2: accumulate and emit ---------------------------------------
    assign w_beat_sum = ACC_WIDTH'(r_s1_lo) + ACC_WIDTH'(r_s1_hi);

`ifdef POPCOUNT_PIPE_SAT_EN
    logic w_clamp;
    logic r_acc_sat;
    logic r_out_sat;

    assign {w_clamp, w_tot} = sat_add(r_acc, w_beat_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_sat <= 1'b0;
            r_out_sat <= 1'b0;
        end else if (w_en && r_s1_valid) begin
            if (r_s1_last) begin
                // A clamp on the last beat itself must still be reported.
                r_out_sat <= r_acc_sat | w_clamp;
                r_acc_sat <= 1'b0;
            end else begin
                r_acc_sat <= r_acc_sat | w_clamp;
            end
        end
    end

    assign out_sat = r_out_sat;
`else
    assign w_tot   = r_acc + w_beat_sum;
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
        end else if (w_en) begin
            if (r_s1_valid && r_s1_last) begin
                r_out_count <= w_tot;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
            end else if (r_s1_valid) begin
                r_acc       <= w_tot;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_popcount_pipe.sv
module tb_popcount_pipe;

    logic        clk;
    logic        rst_n;

    // DUT A: WIDTH=16, ACC_WIDTH=16
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_sat;
    logic [15:0] a_in_data, a_out_count;

    // DUT B: WIDTH=16, ACC_WIDTH=5 (saturation / wrap behaviour)
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
    logic [15:0] b_in_data;
    logic [4:0]  b_out_count;

    int n_checks = 0;
    int n_errors = 0;

    popcount_pipe #(.WIDTH(16), .ACC_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count), .out_sat(a_out_sat)
    );

    popcount_pipe #(.WIDTH(16), .ACC_WIDTH(5)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count), .out_sat(b_out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offers one beat to DUT A and returns #1 after the accepting edge.
    task automatic send_a(input logic [15:0] d, input logic l);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = l;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic l);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = l;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        exp_valid;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[10];

    // Streaming scoreboard for DUT A.
    // mode 0: single-beat packets 0xFFFF>>k, continuous in_valid, out_ready 1,0,0,...
    // mode 1: random packets of 1..4 beats, random in_valid and out_ready
    task automatic stream(input int mode, input int n_pkts);
        logic [15:0] q_data[$];
        bit          q_last[$];
        logic [15:0] q_exp[$];
        logic [15:0] tot;
        logic [15:0] held;
        int          len, sent, got, cyc;
        bit          stalled;
        for (int p = 0; p < n_pkts; p++) begin
            len = (mode == 0) ? 1 : int'($urandom_range(1, 4));
            tot = '0;
            for (int b = 0; b < len; b++) begin
                logic [15:0] d;
                d = (mode == 0) ? (16'hFFFF >> p) : 16'($urandom);
                q_data.push_back(d);
                q_last.push_back(b == len - 1);
                tot = tot + 16'($countones(d));
            end
            q_exp.push_back(tot);
        end
        sent = 0; got = 0; cyc = 0; stalled = 0; held = '0;
        while (got < n_pkts && cyc < 2000) begin
            @(posedge clk); #1;
            a_out_ready = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            a_in_valid  = (sent < q_data.size()) && ((mode == 0) || ($urandom_range(0, 3) != 0));
            a_in_data   = (sent < q_data.size()) ? q_data[sent] : 16'h0;
            a_in_last   = (sent < q_data.size()) ? q_last[sent] : 1'b0;
            #4;
            chk("in_ready_vs_stall", a_in_ready, !(a_out_valid && !a_out_ready));
            if (stalled) begin
                chk("held_valid", a_out_valid, 1);
                chk("held_count", a_out_count, held);
            end
            if (a_in_valid && a_in_ready) sent++;
            if (a_out_valid && a_out_ready) begin
                chk("stream_total", a_out_count, q_exp[got]);
                got++;
            end
            stalled = a_out_valid && !a_out_ready;
            held    = a_out_count;
            cyc++;
        end
        chk("stream_all_delivered", got, n_pkts);
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_in_last   = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'h0000, 1'b1, 1'b1, 16'd0};
        vecs[1] = '{16'hFFFF, 1'b1, 1'b1, 16'd16};
        vecs[2] = '{16'h8001, 1'b1, 1'b1, 16'd2};
        vecs[3] = '{16'h5A5A, 1'b1, 1'b1, 16'd8};
        vecs[4] = '{16'h00FF, 1'b0, 1'b0, 16'd0};
        vecs[5] = '{16'h0F0F, 1'b0, 1'b0, 16'd0};
        vecs[6] = '{16'hFFFF, 1'b1, 1'b1, 16'd32};
        vecs[7] = '{16'h1234, 1'b1, 1'b1, 16'd5};
        vecs[8] = '{16'hFFFF, 1'b0, 1'b0, 16'd0};
        vecs[9] = '{16'h0001, 1'b1, 1'b1, 16'd17};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_count", a_out_count, 0);
        chk("reset_out_sat", a_out_sat, 0);
        chk("reset_in_ready", a_in_ready, 1);
        chk("reset_b_out_valid", b_out_valid, 0);
        chk("reset_b_out_count", b_out_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: each beat is followed by one idle cycle; the result is due one edge after accept.
        for (int i = 0; i < 10; i++) begin
            send_a(vecs[i].data, vecs[i].last);
            chk($sformatf("vec%0d_early_valid", i), a_out_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), a_out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_count", i), a_out_count, vecs[i].exp_count);
            chk($sformatf("vec%0d_sat", i), a_out_sat, 0);
        end

        // Reset mid-packet: the partial 32 must be discarded.
        send_a(16'hFFFF, 1'b0);
        send_a(16'hFFFF, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_count", a_out_count, 0);
        chk("midrst_in_ready", a_in_ready, 1);
        rst_n = 1'b1;
        send_a(16'h0003, 1'b1);
        @(posedge clk); #1;
        chk("midrst_after_valid", a_out_valid, 1);
        chk("midrst_after_count", a_out_count, 2);

        // Saturation vs wrap on the 5-bit accumulator: 3 x 16 = 48.
        send_b(16'hFFFF, 1'b0);
        send_b(16'hFFFF, 1'b0);
        send_b(16'hFFFF, 1'b1);
        @(posedge clk); #1;
        chk("sat_valid", b_out_valid, 1);
`ifdef POPCOUNT_PIPE_SAT_EN
        chk("sat_count", b_out_count, 31);
        chk("sat_flag", b_out_sat, 1);
`else
        chk("wrap_count", b_out_count, 16);
        chk("wrap_flag", b_out_sat, 0);
`endif
        send_b(16'h0001, 1'b1);
        @(posedge clk); #1;
        chk("sat_next_valid", b_out_valid, 1);
        chk("sat_next_count", b_out_count, 1);
        chk("sat_next_flag", b_out_sat, 0);

        stream(0, 10);
        stream(1, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
